knn_vote_sink: RTL and testbench

- Consumer end of the distance-engine output handshake.
- Accepts one tagged distance word per cycle from the distance stage and keeps a sorted list of the K smallest distances with their class tags.
- After the programmed sample count has been consumed, runs a majority vote over the K entries and presents the winning class with a valid/yumi handshake.
- Sits between the distance stage and the host/result interface of the KNN accelerator.

---
 rtl/knn_vote_sink_if.sv | 28 ++
 rtl/knn_vote_sink.sv | 203 ++++++++++++++++++++
 tb/tb_knn_vote_sink.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/knn_vote_sink_if.sv
// Handshake bundle between the distance stage/host and the KNN vote sink.
// The sink uses the slave modport; the driving side uses master.
interface knn_vote_sink_if #(
  parameter int WIDTH    = 4,
  parameter int TAG      = 2,
  parameter int MEM_SIZE = 1024
) ();
  logic                        start_i;
  logic [$clog2(MEM_SIZE)-1:0] num_i;
  logic [TAG+2*WIDTH-1:0]      dist_i;
  logic                        valid_i;
  logic                        yumi_o;
  logic                        ready_o;
  logic [TAG-1:0]              class_o;
  logic                        class_v_o;
  logic                        class_yumi_i;
  logic                        busy_o;

  modport master (
    output start_i, num_i, dist_i, valid_i, class_yumi_i,
    input  yumi_o, ready_o, class_o, class_v_o, busy_o
  );

  modport slave (
    input  start_i, num_i, dist_i, valid_i, class_yumi_i,
    output yumi_o, ready_o, class_o, class_v_o, busy_o
  );
endinterface

// File: rtl/knn_vote_sink.sv
// KNN vote sink: consumes tagged distances, keeps the K nearest in a sorted
// list, then runs a majority vote and offers the winning class with a
// valid/yumi handshake.
module knn_vote_sink #(
  parameter int WIDTH    = 4,
  parameter int TAG      = 2,
  parameter int K        = 3,
  parameter int MEM_SIZE = 1024
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  knn_vote_sink_if.slave bus
);
  localparam int DW = 2 * WIDTH;
  localparam int NW = $clog2(MEM_SIZE);
  localparam int NC = 1 << TAG;
  localparam int CW = $clog2(K + 1);
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_VOTE    = 3'd2,
    S_RESOLVE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state;
  logic [NW-1:0]   num_r;
  logic [NW-1:0]   cnt_r;
  logic [IW-1:0]   idx_r;
  logic [DW-1:0]   ent_dist [K];
  logic [TAG-1:0]  ent_tag  [K];
  logic [K-1:0]    ent_vld;
  logic [CW-1:0]   votes    [NC];
  logic [TAG-1:0]  class_r;
  logic            class_v_r;
  logic            ready_r;
  logic            busy_r;

  logic            accept;
  logic [DW-1:0]   new_dist;
  logic [TAG-1:0]  new_tag;
  logic [K-1:0]    gt;
  logic [DW-1:0]   nxt_dist [K];
  logic [TAG-1:0]  nxt_tag  [K];
  logic [K-1:0]    nxt_vld;
  logic [TAG-1:0]  winner;
  logic [CW-1:0]   win_cnt;

  assign accept   = (state == S_COLLECT) && bus.valid_i;
  assign new_dist = bus.dist_i[DW-1:0];
  assign new_tag  = bus.dist_i[TAG+DW-1:DW];

  assign bus.yumi_o    = accept;
  assign bus.ready_o   = ready_r;
  assign bus.busy_o    = busy_r;
  assign bus.class_o   = class_r;
  assign bus.class_v_o = class_v_r;

  // Sorted insertion: the list is a valid prefix sorted ascending, so the
  // "slot is invalid or strictly farther" flags form a monotone run. The
  // first set flag is the insertion point; later slots take their
  // predecessor. Ties leave the older sample in front.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      gt[i] = !ent_vld[i] || (ent_dist[i] > new_dist);
    end
    if (gt[0]) begin
      nxt_dist[0] = new_dist;
      nxt_tag[0]  = new_tag;
      nxt_vld[0]  = 1'b1;
    end else begin
      nxt_dist[0] = ent_dist[0];
      nxt_tag[0]  = ent_tag[0];
      nxt_vld[0]  = ent_vld[0];
    end
    for (int i = 1; i < K; i++) begin
      if (!gt[i]) begin
        nxt_dist[i] = ent_dist[i];
        nxt_tag[i]  = ent_tag[i];
        nxt_vld[i]  = ent_vld[i];
      end else if (!gt[i-1]) begin
        nxt_dist[i] = new_dist;
        nxt_tag[i]  = new_tag;
        nxt_vld[i]  = 1'b1;
      end else begin
        nxt_dist[i] = ent_dist[i-1];
        nxt_tag[i]  = ent_tag[i-1];
        nxt_vld[i]  = ent_vld[i-1];
      end
    end
  end

  // Winner pick: walk from the farthest entry to the nearest with >=, so the
  // class with the highest count wins and a count tie goes to the class
  // owning the nearest entry.
  always_comb begin
    winner  = {TAG{1'b0}};
    win_cnt = {CW{1'b0}};
    for (int j = K - 1; j >= 0; j--) begin
      if (ent_vld[j] && (votes[ent_tag[j]] >= win_cnt)) begin
        winner  = ent_tag[j];
        win_cnt = votes[ent_tag[j]];
      end else begin
        winner  = winner;
        win_cnt = win_cnt;
      end
    end
  end

  // Control FSM with the entry list, vote counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= S_IDLE;
      num_r     <= {NW{1'b0}};
      cnt_r     <= {NW{1'b0}};
      idx_r     <= {IW{1'b0}};
      ent_vld   <= {K{1'b0}};
      class_r   <= {TAG{1'b0}};
      class_v_r <= 1'b0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      for (int i = 0; i < K; i++) begin
        ent_dist[i] <= {DW{1'b0}};
        ent_tag[i]  <= {TAG{1'b0}};
      end
      for (int c = 0; c < NC; c++) begin
        votes[c] <= {CW{1'b0}};
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            num_r   <= bus.num_i;
            cnt_r   <= {NW{1'b0}};
            idx_r   <= {IW{1'b0}};
            ent_vld <= {K{1'b0}};
            for (int c = 0; c < NC; c++) begin
              votes[c] <= {CW{1'b0}};
            end
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            state   <= S_COLLECT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_COLLECT: begin
          if (accept) begin
            ent_vld <= nxt_vld;
            for (int i = 0; i < K; i++) begin
              ent_dist[i] <= nxt_dist[i];
              ent_tag[i]  <= nxt_tag[i];
            end
            cnt_r <= cnt_r + {{(NW-1){1'b0}}, 1'b1};
            if (cnt_r == num_r) begin
              state <= S_VOTE;
            end else begin
              state <= S_COLLECT;
            end
          end else begin
            state <= S_COLLECT;
          end
        end
        S_VOTE: begin
          if (ent_vld[idx_r]) begin
            votes[ent_tag[idx_r]] <= votes[ent_tag[idx_r]] + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            votes[ent_tag[idx_r]] <= votes[ent_tag[idx_r]];
          end
          if (idx_r == IW'(K - 1)) begin
            state <= S_RESOLVE;
          end else begin
            idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
            state <= S_VOTE;
          end
        end
        S_RESOLVE: begin
          class_r   <= winner;
          class_v_r <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.class_yumi_i && class_v_r) begin
            class_v_r <= 1'b0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            state     <= S_IDLE;
          end else begin
            state <= S_DONE;
          end
        end
        default: begin
          state     <= S_IDLE;
          class_v_r <= 1'b0;
          ready_r   <= 1'b1;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_knn_vote_sink.sv
// Self-checking bench for knn_vote_sink: directed cases plus randomized
// queries checked against a selection-and-count reference model.
module tb_knn_vote_sink;
  localparam int WIDTH    = 4;
  localparam int TAG      = 2;
  localparam int K        = 3;
  localparam int MEM_SIZE = 1024;
  localparam int DW       = 2 * WIDTH;
  localparam int NC       = 1 << TAG;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  int   yumi_cnt;
  int   s_tag[$];
  int   s_dist[$];

  knn_vote_sink_if #(.WIDTH(WIDTH), .TAG(TAG), .MEM_SIZE(MEM_SIZE)) ifc ();

  knn_vote_sink #(.WIDTH(WIDTH), .TAG(TAG), .K(K), .MEM_SIZE(MEM_SIZE)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle counter and running count of accepted words
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifc.yumi_o === 1'b1) yumi_cnt <= yumi_cnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: stable pick of the K nearest samples (ties keep arrival
  // order), count their classes, highest count wins, tie to nearest rank.
  function automatic int model_class();
    int n;
    int rank_tag[$];
    bit used[];
    int cnt[NC];
    int best;
    int best_cnt;
    n = s_tag.size();
    used = new[n];
    for (int r = 0; r < K && r < n; r++) begin
      int pick;
      pick = -1;
      for (int i = 0; i < n; i++) begin
        if (!used[i] && (pick < 0 || s_dist[i] < s_dist[pick])) pick = i;
      end
      used[pick] = 1'b1;
      rank_tag.push_back(s_tag[pick]);
    end
    for (int c = 0; c < NC; c++) cnt[c] = 0;
    foreach (rank_tag[r]) cnt[rank_tag[r]]++;
    best = 0;
    best_cnt = 0;
    foreach (rank_tag[r]) begin
      if (cnt[rank_tag[r]] > best_cnt) begin
        best = rank_tag[r];
        best_cnt = cnt[rank_tag[r]];
      end
    end
    return best;
  endfunction

  // present one word and wait (bounded) for its accept
  task automatic send_sample(input int t, input int d, output int acc_cyc);
    int gap;
    gap = $urandom_range(0, 2);
    ifc.valid_i = 1'b0;
    repeat (gap) step();
    ifc.valid_i = 1'b1;
    ifc.dist_i  = {TAG'(t), DW'(d)};
    acc_cyc = -1;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (ifc.yumi_o === 1'b1) begin
        acc_cyc = cyc;
        step();
        break;
      end
      step();
    end
    if (acc_cyc < 0) check("accept_timeout", 0, 1);
  endtask

  task automatic start_query(input int num);
    check("ready_idle", int'(ifc.ready_o), 1);
    ifc.start_i = 1'b1;
    ifc.num_i   = num[$clog2(MEM_SIZE)-1:0];
    step();
    ifc.start_i = 1'b0;
    ifc.num_i   = 10'($urandom);
  endtask

  task automatic run_query(input int hold_pre, input int ack_delay);
    int n;
    int exp_cls;
    int y0;
    int last_acc;
    int rise;
    int cls_seen;
    n = s_tag.size();
    exp_cls = model_class();
    if (hold_pre > 0) begin
      ifc.valid_i = 1'b1;
      ifc.dist_i  = {TAG'(s_tag[0]), DW'(s_dist[0])};
      for (int h = 0; h < hold_pre; h++) begin
        @(negedge clk);
        check("yumi_in_idle", int'(ifc.yumi_o), 0);
        step();
      end
    end
    y0 = yumi_cnt;
    start_query(n - 1);
    last_acc = -1;
    for (int i = 0; i < n; i++) begin
      send_sample(s_tag[i], s_dist[i], last_acc);
      if (last_acc < 0) return;
    end
    // keep a junk word pending: it must not be taken outside COLLECT
    ifc.valid_i = 1'b1;
    ifc.dist_i  = (TAG + DW)'($urandom);
    rise = -1;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (ifc.class_v_o === 1'b1) begin
        rise = cyc;
        break;
      end
      step();
    end
    if (rise < 0) begin
      check("class_v_timeout", 0, 1);
      return;
    end
    check("latency", rise - last_acc, K + 2);
    check("class", int'(ifc.class_o), exp_cls);
    check("busy_done", int'(ifc.busy_o), 1);
    cls_seen = int'(ifc.class_o);
    step();
    for (int h = 0; h < ack_delay; h++) begin
      @(negedge clk);
      check("class_v_hold", int'(ifc.class_v_o), 1);
      check("class_hold", int'(ifc.class_o), cls_seen);
      step();
    end
    check("yumi_count", yumi_cnt - y0, n);
    ifc.valid_i = 1'b0;
    ifc.class_yumi_i = 1'b1;
    step();
    ifc.class_yumi_i = 1'b0;
    check("class_v_after_ack", int'(ifc.class_v_o), 0);
    check("ready_after_ack", int'(ifc.ready_o), 1);
    check("busy_after_ack", int'(ifc.busy_o), 0);
  endtask

  initial begin
    int dummy;
    total = 0;
    bad = 0;
    cyc = 0;
    yumi_cnt = 0;
    rst_n = 1'b0;
    ifc.start_i = 1'b0;
    ifc.num_i = '0;
    ifc.dist_i = '0;
    ifc.valid_i = 1'b0;
    ifc.class_yumi_i = 1'b0;
    repeat (3) step();
    check("rst_ready", int'(ifc.ready_o), 1);
    check("rst_busy", int'(ifc.busy_o), 0);
    check("rst_class_v", int'(ifc.class_v_o), 0);
    check("rst_class", int'(ifc.class_o), 0);
    check("rst_yumi", int'(ifc.yumi_o), 0);
    rst_n = 1'b1;
    step();

    // basic query, with valid held in IDLE and a slow acknowledge
    s_tag = '{1, 2, 1, 3, 1};
    s_dist = '{9, 3, 5, 12, 7};
    run_query(3, 10);

    // distance ties keep arrival order
    s_tag = '{0, 2, 2, 0};
    s_dist = '{6, 6, 6, 6};
    run_query(0, 2);

    // 1/1/1 vote tie goes to the nearest entry's class
    s_tag = '{3, 1, 0};
    s_dist = '{2, 1, 4};
    run_query(0, 1);

    // single-sample query
    s_tag = '{2};
    s_dist = '{15};
    run_query(0, 0);

    // reset in the middle of COLLECT
    start_query(4);
    send_sample(1, 0, dummy);
    send_sample(1, 0, dummy);
    ifc.valid_i = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_yumi", int'(ifc.yumi_o), 0);
    check("midrst_ready", int'(ifc.ready_o), 1);
    check("midrst_busy", int'(ifc.busy_o), 0);
    check("midrst_class_v", int'(ifc.class_v_o), 0);
    check("midrst_class", int'(ifc.class_o), 0);
    step();
    rst_n = 1'b1;
    ifc.valid_i = 1'b0;
    step();
    s_tag = '{3, 3};
    s_dist = '{0, 1};
    run_query(0, 0);

    // randomized queries
    for (int q = 0; q < 25; q++) begin
      int n;
      n = $urandom_range(1, 12);
      s_tag.delete();
      s_dist.delete();
      for (int i = 0; i < n; i++) begin
        s_tag.push_back($urandom_range(0, NC - 1));
        s_dist.push_back($urandom_range(0, 15) * (($urandom_range(0, 3) == 0) ? 16 : 1));
      end
      run_query($urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
